// File: rtl/seven_seg_mux_if.sv
// seven_seg_mux_if: display register bundle between host and scanner.
// master drives digits/controls, slave returns segment and select pins.
interface seven_seg_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [5*NUM_DIGITS-1:0] value_in;
  logic [8*NUM_DIGITS-1:0] bit_array_in;
  logic                    anim_en_in;
  logic                    blank_lz_in;
  logic [NUM_DIGITS-1:0]   blink_mask_in;
  logic                    display_on_in;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   digit_sel_out;

  modport master (
    output value_in,
    output bit_array_in,
    output anim_en_in,
    output blank_lz_in,
    output blink_mask_in,
    output display_on_in,
    input  seg_out,
    input  digit_sel_out
  );

  modport slave (
    input  value_in,
    input  bit_array_in,
    input  anim_en_in,
    input  blank_lz_in,
    input  blink_mask_in,
    input  display_on_in,
    output seg_out,
    output digit_sel_out
  );
endinterface

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed common-cathode 7-seg scanner.
// Ports: clk, rst_n (async low), bus (slave: digits in, seg/sel out).
module seven_seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_LOG2   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_mux_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int ND = NUM_DIGITS;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [BLINK_LOG2-1:0] r_fcnt;

  logic [5*ND-1:0]       r_val;
  logic [8*ND-1:0]       r_bits;
  logic                  r_anim;
  logic                  r_lz;
  logic [ND-1:0]         r_blink;

  logic [7:0]            r_seg;
  logic [ND-1:0]         r_sel;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [ND-1:0]         w_hi_zero;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic [7:0]            w_bits;
  logic                  w_blink;
  logic                  w_sup;
  logic                  w_blank;
  logic [6:0]            w_font;
  logic [7:0]            w_seg_nxt;
  logic [ND-1:0]         w_sel_nxt;

  assign w_slot_end  = (r_presc == PW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(ND - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_presc <= '0;
      if (r_idx == IW'(ND - 1))
        r_idx <= '0;
      else
        r_idx <= r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Inputs are captured only on frame wrap so a
  // frame never mixes old and new digit values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_val   <= '0;
      r_bits  <= '0;
      r_anim  <= 1'b0;
      r_lz    <= 1'b0;
      r_blink <= '0;
    end else if (w_frame_end) begin
      r_fcnt  <= r_fcnt + 1'b1;
      r_val   <= bus.value_in;
      r_bits  <= bus.bit_array_in;
      r_anim  <= bus.anim_en_in;
      r_lz    <= bus.blank_lz_in;
      r_blink <= bus.blink_mask_in;
    end
  end

  // w_hi_zero[i]: nibble i and every more
  // significant nibble are zero.
  always_comb begin
    w_hi_zero = '1;
    for (int i = 0; i < ND; i++) begin
      for (int j = 0; j < ND; j++) begin
        if (j >= i && r_val[5*j +: 4] != 4'h0)
          w_hi_zero[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_nib   = '0;
    w_dp    = 1'b0;
    w_bits  = '0;
    w_blink = 1'b0;
    w_sup   = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = r_val[5*i +: 4];
        w_dp    = r_val[5*i + 4];
        w_bits  = r_bits[8*i +: 8];
        w_blink = r_blink[i];
        w_sup   = (i != 0) && w_hi_zero[i];
      end
    end
  end

  always_comb begin
    w_font = 7'h00;
    case (w_nib)
      4'h0: w_font = 7'h3F;
      4'h1: w_font = 7'h06;
      4'h2: w_font = 7'h5B;
      4'h3: w_font = 7'h4F;
      4'h4: w_font = 7'h66;
      4'h5: w_font = 7'h6D;
      4'h6: w_font = 7'h7D;
      4'h7: w_font = 7'h07;
      4'h8: w_font = 7'h7F;
      4'h9: w_font = 7'h67;
      4'hA: w_font = 7'h77;
      4'hB: w_font = 7'h7C;
      4'hC: w_font = 7'h39;
      4'hD: w_font = 7'h5E;
      4'hE: w_font = 7'h79;
      4'hF: w_font = 7'h71;
      default: w_font = 7'h00;
    endcase
  end

  // Blank at slot start (anti-ghosting), when
  // disabled, or in the dark half of a blink.
  assign w_blank = (r_presc < PW'(BLANK_CYCLES))
                || !bus.display_on_in
                || (w_blink && r_fcnt[BLINK_LOG2-1]);

  always_comb begin
    w_seg_nxt = '0;
    w_sel_nxt = '0;
    if (!w_blank) begin
      w_sel_nxt = ND'(1) << r_idx;
      if (r_anim)
        w_seg_nxt = w_bits;
      else if (r_lz && w_sup)
        w_seg_nxt = {w_dp, 7'h00};
      else
        w_seg_nxt = {w_dp, w_font};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_sel <= '0;
    end else begin
      r_seg <= w_seg_nxt;
      r_sel <= w_sel_nxt;
    end
  end

  assign bus.seg_out       = r_seg;
  assign bus.digit_sel_out = r_sel;

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed + random scan checks
// against a time-indexed model of the display.
module tb_seven_seg_mux;

  localparam int N   = 4;
  localparam int SD  = 8;
  localparam int BC  = 2;
  localparam int BL  = 2;
  localparam int FR  = N * SD;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_mux_if #(.NUM_DIGITS(N)) ifc();

  seven_seg_mux #(
    .NUM_DIGITS(N),
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC),
    .BLINK_LOG2(BL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc.slave)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  int               m_t = 0;
  logic [5*N-1:0]   s_val = '0;
  logic [8*N-1:0]   s_bits = '0;
  logic             s_anim = 1'b0;
  logic             s_lz = 1'b0;
  logic [N-1:0]     s_blink = '0;
  logic [11:0]      m_exp = '0;

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d seg/sel got %h want %h",
               name, m_t, act, exp);
    end
  endtask

  // Display content as a function of cycles since
  // reset and the snapshot taken at frame start.
  function automatic logic [11:0] model_out(int t, logic on);
    int p, d, fc, hi;
    logic [7:0] s;
    logic [3:0] nib;
    p  = t % SD;
    d  = (t / SD) % N;
    fc = (t / FR) % (1 << BL);
    if (p < BC || !on) return 12'h0;
    if (s_blink[d] && fc >= (1 << (BL - 1))) return 12'h0;
    if (s_anim) begin
      s = s_bits[8*d +: 8];
    end else begin
      nib = s_val[5*d +: 4];
      hi = 0;
      for (int i = d; i < N; i++) hi += int'(s_val[5*i +: 4]);
      s = {s_val[5*d + 4],
           (s_lz && d > 0 && hi == 0) ? 7'h00 : FONT[nib]};
    end
    return {s, 4'(1 << d)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= 0;
      s_val   <= '0;
      s_bits  <= '0;
      s_anim  <= 1'b0;
      s_lz    <= 1'b0;
      s_blink <= '0;
      m_exp   <= '0;
    end else begin
      m_exp <= model_out(m_t, ifc.display_on_in);
      if (m_t % FR == FR - 1) begin
        s_val   <= ifc.value_in;
        s_bits  <= ifc.bit_array_in;
        s_anim  <= ifc.anim_en_in;
        s_lz    <= ifc.blank_lz_in;
        s_blink <= ifc.blink_mask_in;
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      chk("scan", {ifc.seg_out, ifc.digit_sel_out}, m_exp);
  end

  task automatic wait_t(int target);
    int guard;
    guard = 0;
    while (m_t < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (m_t != target) begin
      tests++;
      fails++;
      $display("FAIL wait t=%0d got %0d want %0d", m_t, m_t, target);
    end
  endtask

  task automatic lit(string name, int target, logic [7:0] seg, logic [3:0] sel);
    wait_t(target);
    chk(name, {ifc.seg_out, ifc.digit_sel_out}, {seg, sel});
  endtask

  // Slot (frame f, digit d), first lit cycle.
  function automatic int at(int f, int d);
    return f * FR + d * SD + BC + 1;
  endfunction

  initial begin
    ifc.value_in      = '0;
    ifc.bit_array_in  = '0;
    ifc.anim_en_in    = 1'b0;
    ifc.blank_lz_in   = 1'b0;
    ifc.blink_mask_in = '0;
    ifc.display_on_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    lit("rst_e1", 1, 8'h00, 4'b0000);
    lit("rst_e2", 2, 8'h00, 4'b0000);
    lit("rst_e3", 3, 8'h3F, 4'b0001);
    lit("rst_e8", 8, 8'h3F, 4'b0001);
    lit("rst_e9", 9, 8'h00, 4'b0000);
    lit("rst_e11", 11, 8'h3F, 4'b0010);

    ifc.value_in = {5'h0A, 5'h07, 5'h10, 5'h05};
    lit("dec_d0", at(1, 0), 8'h6D, 4'b0001);
    lit("dec_d1", at(1, 1), 8'hBF, 4'b0010);
    lit("dec_d2", at(1, 2), 8'h07, 4'b0100);
    lit("dec_d3", at(1, 3), 8'h77, 4'b1000);

    ifc.blank_lz_in = 1'b1;
    ifc.value_in = {5'h00, 5'h00, 5'h03, 5'h00};
    lit("lz_d0", at(2, 0), 8'h3F, 4'b0001);
    lit("lz_d1", at(2, 1), 8'h4F, 4'b0010);
    lit("lz_d2", at(2, 2), 8'h00, 4'b0100);
    lit("lz_d3", at(2, 3), 8'h00, 4'b1000);

    ifc.blank_lz_in = 1'b0;
    ifc.anim_en_in = 1'b1;
    ifc.bit_array_in = {4{8'h81}};
    lit("anim_d0", at(3, 0), 8'h81, 4'b0001);
    lit("anim_d1", at(3, 1), 8'h81, 4'b0010);
    ifc.bit_array_in = {4{8'hFF}};
    lit("tear_d2", at(3, 2), 8'h81, 4'b0100);
    lit("tear_d3", at(3, 3), 8'h81, 4'b1000);
    lit("anim_new", at(4, 0), 8'hFF, 4'b0001);

    ifc.blink_mask_in = 4'b0100;
    lit("blk_on5", at(5, 2), 8'hFF, 4'b0100);
    lit("blk_d1_6", at(6, 1), 8'hFF, 4'b0010);
    lit("blk_off6", at(6, 2), 8'h00, 4'b0000);
    lit("blk_off7", at(7, 2), 8'h00, 4'b0000);
    lit("blk_d3_7", at(7, 3), 8'hFF, 4'b1000);
    lit("blk_on8", at(8, 2), 8'hFF, 4'b0100);

    ifc.display_on_in = 1'b0;
    @(negedge clk);
    chk("don_off", {ifc.seg_out, ifc.digit_sel_out}, 12'h000);
    ifc.display_on_in = 1'b1;
    @(negedge clk);
    chk("don_back", {ifc.seg_out, ifc.digit_sel_out}, {8'hFF, 4'b0100});

    for (int c = 0; c < 150 * FR; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int d = 0; d < N; d++) begin
          ifc.value_in[5*d +: 4] =
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
          ifc.value_in[5*d + 4] = 1'($urandom);
        end
        ifc.bit_array_in  = $urandom;
        ifc.anim_en_in    = ($urandom_range(0, 3) == 0);
        ifc.blank_lz_in   = 1'($urandom);
        ifc.blink_mask_in = 4'($urandom);
      end
      if ($urandom_range(0, 39) == 0)
        ifc.display_on_in = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    ifc.display_on_in = 1'b1;
    ifc.value_in = {5'h01, 5'h02, 5'h03, 5'h04};
    repeat (SD + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {ifc.seg_out, ifc.digit_sel_out}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    lit("rst2_e1", 1, 8'h00, 4'b0000);
    lit("rst2_e3", 3, 8'h3F, 4'b0001);
    lit("rst2_e11", 11, 8'h3F, 4'b0010);
    lit("rst2_new", at(1, 0), 8'h66, 4'b0001);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
